// File: rtl/recovery_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | recovery_sequencer_if                                                      |
// | Recovery datapath bundle between the sequencer and comparator/sgpr/spc/cores|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface recovery_sequencer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  error_i;
    logic [ADDR_WIDTH-1:0] sgpr_raddr_o;
    logic [DATA_WIDTH-1:0] sgpr_rdata_i;
    logic                  sgpr_wblock_o;
    logic [DATA_WIDTH-1:0] spc_i;
    logic                  core_rf_we_o;
    logic [ADDR_WIDTH-1:0] core_rf_waddr_o;
    logic [DATA_WIDTH-1:0] core_rf_wdata_o;
    logic                  core_pc_we_o;
    logic [DATA_WIDTH-1:0] core_pc_o;
    logic                  fetch_block_o;
    logic                  done_o;
    logic [CNT_WIDTH-1:0]  recovery_cnt_o;

    modport master (
        input  error_i, sgpr_rdata_i, spc_i,
        output sgpr_raddr_o, sgpr_wblock_o, core_rf_we_o, core_rf_waddr_o,
               core_rf_wdata_o, core_pc_we_o, core_pc_o, fetch_block_o,
               done_o, recovery_cnt_o
    );

    modport slave (
        output error_i, sgpr_rdata_i, spc_i,
        input  sgpr_raddr_o, sgpr_wblock_o, core_rf_we_o, core_rf_waddr_o,
               core_rf_wdata_o, core_pc_we_o, core_pc_o, fetch_block_o,
               done_o, recovery_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/recovery_sequencer.sv
// +----------------------------------------------------------------------------+
// | recovery_sequencer                                                         |
// | Lockstep rollback: freeze fetch, drain, copy sgpr into core RFs, restore PC.|
// | Optional feature macro: RECOVERY_CNT_EN (saturating recovery counter).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module recovery_sequencer #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    recovery_sequencer_if.master bus
);

    localparam int c_DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [c_DRAIN_W-1:0]  c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES);
    localparam logic [c_DRAIN_W-1:0]  c_DRAIN_ONE  = c_DRAIN_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_FIRST_ADDR = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_RESTORE = 3'd2,
        S_PC      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_DRAIN_W-1:0]  r_drain_cnt;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  r_rf_we;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic                  r_pc_we;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_fetch_block;
    logic                  r_wblock;
    logic                  r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_drain_cnt   <= '0;
            r_raddr       <= '0;
            r_rf_we       <= 1'b0;
            r_rf_waddr    <= '0;
            r_rf_wdata    <= '0;
            r_pc_we       <= 1'b0;
            r_pc          <= '0;
            r_fetch_block <= 1'b0;
            r_wblock      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_rf_we <= 1'b0;
            r_pc_we <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                // An error seen in DONE chains straight into a new recovery,
                // so fetch stays blocked without a gap.
                S_IDLE, S_DONE: begin
                    if (bus.error_i) begin
                        r_fetch_block <= 1'b1;
                        r_wblock      <= 1'b1;
                        r_drain_cnt   <= c_DRAIN_LOAD;
                        if (DRAIN_CYCLES == 0) begin
                            r_state <= S_RESTORE;
                            r_raddr <= c_FIRST_ADDR;
                        end else begin
                            r_state <= S_DRAIN;
                            r_raddr <= '0;
                        end
                    end else begin
                        r_state       <= S_IDLE;
                        r_fetch_block <= 1'b0;
                        r_wblock      <= 1'b0;
                        r_raddr       <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt <= c_DRAIN_ONE) begin
                        r_state <= S_RESTORE;
                        r_raddr <= c_FIRST_ADDR;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_DRAIN_ONE;
                    end
                end
                // The write for address A lands one cycle after A was read.
                S_RESTORE: begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= r_raddr;
                    r_rf_wdata <= bus.sgpr_rdata_i;
                    if (r_raddr == c_LAST_ADDR) begin
                        r_state <= S_PC;
                        r_pc_we <= 1'b1;
                        r_pc    <= bus.spc_i;
                    end else begin
                        r_raddr <= r_raddr + c_FIRST_ADDR;
                    end
                end
                S_PC: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RECOVERY_CNT_EN
    logic                 w_start;
    logic [CNT_WIDTH-1:0] r_rec_cnt;

    assign w_start = bus.error_i && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec_cnt <= '0;
        end else if (w_start && (r_rec_cnt != {CNT_WIDTH{1'b1}})) begin
            r_rec_cnt <= r_rec_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.recovery_cnt_o = r_rec_cnt;
`else
    assign bus.recovery_cnt_o = {CNT_WIDTH{1'b0}};
`endif

    assign bus.sgpr_raddr_o    = r_raddr;
    assign bus.sgpr_wblock_o   = r_wblock;
    assign bus.core_rf_we_o    = r_rf_we;
    assign bus.core_rf_waddr_o = r_rf_waddr;
    assign bus.core_rf_wdata_o = r_rf_wdata;
    assign bus.core_pc_we_o    = r_pc_we;
    assign bus.core_pc_o       = r_pc;
    assign bus.fetch_block_o   = r_fetch_block;
    assign bus.done_o          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_recovery_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_recovery_sequencer                                                      |
// | Randomized bench: default instance plus NUM_REGS=16/DRAIN=0/CNT_WIDTH=2.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_recovery_sequencer;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int NR   = 32;
    localparam int DC   = 2;
    localparam int NR_B = 16;
    localparam int DC_B = 0;
    localparam int CW_B = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    recovery_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW))   bus_a ();
    recovery_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW_B)) bus_b ();

    recovery_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                         .DRAIN_CYCLES(DC), .CNT_WIDTH(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.master));

    recovery_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR_B),
                         .DRAIN_CYCLES(DC_B), .CNT_WIDTH(CW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.master));

    // Shadow register files, read combinationally
    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];
    assign bus_a.sgpr_rdata_i = mem_a[bus_a.sgpr_raddr_o];
    assign bus_b.sgpr_rdata_i = mem_b[bus_b.sgpr_raddr_o];

    int n_cmp = 0;
    int n_err = 0;
    int rec_a = 0;
    int rec_b = 0;

    // Observation log: everything the cores would see, one entry per event
    logic [AW-1:0] wa_a [$];
    logic [DW-1:0] wd_a [$];
    logic [DW-1:0] pc_a [$];
    int            run_a_q [$];
    int            done_a = 0, run_a = 0, viol_a = 0;
    logic [AW-1:0] wa_b [$];
    logic [DW-1:0] wd_b [$];
    logic [DW-1:0] pc_b [$];
    int            run_b_q [$];
    int            done_b = 0, run_b = 0, viol_b = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            run_a = 0;
        end else begin
            if (bus_a.core_rf_we_o) begin
                wa_a.push_back(bus_a.core_rf_waddr_o);
                wd_a.push_back(bus_a.core_rf_wdata_o);
            end
            if (bus_a.core_pc_we_o) pc_a.push_back(bus_a.core_pc_o);
            if (bus_a.done_o) done_a++;
            if (bus_a.fetch_block_o) run_a++;
            else if (run_a > 0) begin run_a_q.push_back(run_a); run_a = 0; end
            if (bus_a.sgpr_wblock_o !== bus_a.fetch_block_o) viol_a++;
            if ((bus_a.core_rf_we_o || bus_a.core_pc_we_o || bus_a.done_o) && !bus_a.fetch_block_o)
                viol_a++;
            if (bus_a.done_o && (bus_a.core_rf_we_o || bus_a.core_pc_we_o)) viol_a++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            run_b = 0;
        end else begin
            if (bus_b.core_rf_we_o) begin
                wa_b.push_back(bus_b.core_rf_waddr_o);
                wd_b.push_back(bus_b.core_rf_wdata_o);
            end
            if (bus_b.core_pc_we_o) pc_b.push_back(bus_b.core_pc_o);
            if (bus_b.done_o) done_b++;
            if (bus_b.fetch_block_o) run_b++;
            else if (run_b > 0) begin run_b_q.push_back(run_b); run_b = 0; end
            if (bus_b.sgpr_wblock_o !== bus_b.fetch_block_o) viol_b++;
            if ((bus_b.core_rf_we_o || bus_b.core_pc_we_o || bus_b.done_o) && !bus_b.fetch_block_o)
                viol_b++;
        end
    end

    function automatic int exp_cnt(input int rec, input int cw);
`ifdef RECOVERY_CNT_EN
        return (rec > (1 << cw) - 1) ? (1 << cw) - 1 : rec;
`else
        return 0;
`endif
    endfunction

    task automatic wait_done(input bit sel_b, input int target);
        int budget = 200;
        while (((sel_b ? done_b : done_a) < target) && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        if (budget == 0) begin
            n_cmp++; n_err++;
            $display("FAIL wait_done: done count %0d required %0d", sel_b ? done_b : done_a, target);
        end
    endtask

    task automatic pulse_error(input bit sel_b, input int len);
        @(posedge clk); #1;
        if (sel_b) bus_b.error_i = 1'b1; else bus_a.error_i = 1'b1;
        repeat (len) @(posedge clk);
        #1;
        if (sel_b) bus_b.error_i = 1'b0; else bus_a.error_i = 1'b0;
    endtask

    task automatic test_reset();
        bus_a.error_i = 1'b0; bus_b.error_i = 1'b0;
        bus_a.spc_i = '0;     bus_b.spc_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        pulse_error(1'b0, 1);
        rec_a = 1;
        repeat (5) @(posedge clk);
        #3;
        n_cmp++;
        if (bus_a.fetch_block_o !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_fetch: got %b want 1", bus_a.fetch_block_o);
        end
        rst_n = 1'b0;
        #1;
        rec_a = 0;
        n_cmp++;
        if ({bus_a.fetch_block_o, bus_a.sgpr_wblock_o, bus_a.core_rf_we_o,
             bus_a.core_pc_we_o, bus_a.done_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 00000", {bus_a.fetch_block_o,
                bus_a.sgpr_wblock_o, bus_a.core_rf_we_o, bus_a.core_pc_we_o, bus_a.done_o});
        end
        n_cmp++;
        if ({bus_a.sgpr_raddr_o, bus_a.core_rf_waddr_o, bus_a.core_rf_wdata_o, bus_a.core_pc_o} !== '0) begin
            n_err++; $display("FAIL reset_data: raddr %0d waddr %0d wdata %h pc %h want all 0",
                bus_a.sgpr_raddr_o, bus_a.core_rf_waddr_o, bus_a.core_rf_wdata_o, bus_a.core_pc_o);
        end
        n_cmp++;
        if (32'(bus_a.recovery_cnt_o) !== 32'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d want 0", bus_a.recovery_cnt_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int wb = wa_a.size(), pb = pc_a.size(), rb = run_a_q.size(), db = done_a;
        for (int i = 0; i < (1 << AW); i++) mem_a[i] = 32'hA5A5_0000 + i;
        bus_a.spc_i = 32'h0000_1F40;
        pulse_error(1'b0, 1);
        rec_a++;
        wait_done(1'b0, db + 1);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (wa_a.size() - wb != NR - 1) begin
            n_err++; $display("FAIL single_wcount: got %0d want %0d", wa_a.size() - wb, NR - 1);
        end
        for (int k = 0; k < NR - 1 && wb + k < wa_a.size(); k++) begin
            n_cmp++;
            if (wa_a[wb+k] !== AW'(k + 1) || wd_a[wb+k] !== 32'hA5A5_0000 + k + 1) begin
                n_err++; $display("FAIL single_write[%0d]: got %0d/%h want %0d/%h", k,
                    wa_a[wb+k], wd_a[wb+k], k + 1, 32'hA5A5_0000 + k + 1);
            end
        end
        n_cmp++;
        if (pc_a.size() - pb != 1 || pc_a[pc_a.size()-1] !== 32'h0000_1F40) begin
            n_err++; $display("FAIL single_pc: got %0d strobes last %h want 1 strobe 00001f40",
                pc_a.size() - pb, pc_a[pc_a.size()-1]);
        end
        n_cmp++;
        if (run_a_q.size() - rb != 1 || run_a_q[run_a_q.size()-1] != DC + NR + 1) begin
            n_err++; $display("FAIL single_fetch: got %0d runs last %0d want 1 run %0d",
                run_a_q.size() - rb, run_a_q[run_a_q.size()-1], DC + NR + 1);
        end
        n_cmp++;
        if (done_a - db != 1) begin
            n_err++; $display("FAIL single_done: got %0d pulses want 1", done_a - db);
        end
        n_cmp++;
        if (32'(bus_a.recovery_cnt_o) !== 32'(exp_cnt(rec_a, CW))) begin
            n_err++; $display("FAIL single_cnt: got %0d want %0d", bus_a.recovery_cnt_o, exp_cnt(rec_a, CW));
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int wb = wa_a.size(), rb = run_a_q.size(), db = done_a;
            logic [DW-1:0] spc = DW'($urandom);
            for (int i = 0; i < (1 << AW); i++) mem_a[i] = DW'($urandom);
            bus_a.spc_i = spc;
            repeat ($urandom_range(10, 1)) @(posedge clk);
            pulse_error(1'b0, $urandom_range(8, 1));
            rec_a++;
            wait_done(1'b0, db + 1);
            repeat (3) @(negedge clk);
            #1;
            n_cmp++;
            if (wa_a.size() - wb != NR - 1) begin
                n_err++; $display("FAIL rand_wcount[%0d]: got %0d want %0d", it, wa_a.size() - wb, NR - 1);
            end
            for (int k = 0; k < NR - 1 && wb + k < wa_a.size(); k++) begin
                n_cmp++;
                if (wa_a[wb+k] !== AW'(k + 1) || wd_a[wb+k] !== mem_a[k+1]) begin
                    n_err++; $display("FAIL rand_write[%0d.%0d]: got %0d/%h want %0d/%h", it, k,
                        wa_a[wb+k], wd_a[wb+k], k + 1, mem_a[k+1]);
                end
            end
            n_cmp++;
            if (pc_a[pc_a.size()-1] !== spc || done_a - db != 1) begin
                n_err++; $display("FAIL rand_pc_done[%0d]: got pc %h done %0d want pc %h done 1",
                    it, pc_a[pc_a.size()-1], done_a - db, spc);
            end
            n_cmp++;
            if (run_a_q.size() - rb != 1 || run_a_q[run_a_q.size()-1] != DC + NR + 1) begin
                n_err++; $display("FAIL rand_fetch[%0d]: got %0d runs last %0d want 1 run %0d", it,
                    run_a_q.size() - rb, run_a_q[run_a_q.size()-1], DC + NR + 1);
            end
        end
        n_cmp++;
        if (32'(bus_a.recovery_cnt_o) !== 32'(exp_cnt(rec_a, CW))) begin
            n_err++; $display("FAIL rand_cnt: got %0d want %0d", bus_a.recovery_cnt_o, exp_cnt(rec_a, CW));
        end
    endtask

    task automatic test_back_to_back();
        int wb = wa_a.size(), pb = pc_a.size(), rb = run_a_q.size(), db = done_a;
        logic [DW-1:0] spc = DW'($urandom);
        for (int i = 0; i < (1 << AW); i++) mem_a[i] = DW'($urandom);
        bus_a.spc_i = spc;
        @(posedge clk); #1; bus_a.error_i = 1'b1;
        wait_done(1'b0, db + 1);
        @(posedge clk); #1; bus_a.error_i = 1'b0;
        rec_a += 2;
        wait_done(1'b0, db + 2);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (wa_a.size() - wb != 2 * (NR - 1)) begin
            n_err++; $display("FAIL b2b_wcount: got %0d want %0d", wa_a.size() - wb, 2 * (NR - 1));
        end
        for (int k = 0; k < 2 * (NR - 1) && wb + k < wa_a.size(); k++) begin
            n_cmp++;
            if (wa_a[wb+k] !== AW'(k % (NR - 1) + 1) || wd_a[wb+k] !== mem_a[k % (NR - 1) + 1]) begin
                n_err++; $display("FAIL b2b_write[%0d]: got %0d/%h want %0d/%h", k, wa_a[wb+k],
                    wd_a[wb+k], k % (NR - 1) + 1, mem_a[k % (NR - 1) + 1]);
            end
        end
        n_cmp++;
        if (pc_a.size() - pb != 2 || done_a - db != 2) begin
            n_err++; $display("FAIL b2b_pc_done: got %0d pc %0d done want 2 2", pc_a.size() - pb, done_a - db);
        end
        n_cmp++;
        if (run_a_q.size() - rb != 1 || run_a_q[run_a_q.size()-1] != 2 * (DC + NR + 1)) begin
            n_err++; $display("FAIL b2b_fetch: got %0d runs last %0d want 1 run %0d",
                run_a_q.size() - rb, run_a_q[run_a_q.size()-1], 2 * (DC + NR + 1));
        end
        n_cmp++;
        if (32'(bus_a.recovery_cnt_o) !== 32'(exp_cnt(rec_a, CW))) begin
            n_err++; $display("FAIL b2b_cnt: got %0d want %0d", bus_a.recovery_cnt_o, exp_cnt(rec_a, CW));
        end
    endtask

    task automatic test_reset_mid_restore();
        int wb = wa_a.size(), db, budget = 100;
        for (int i = 0; i < (1 << AW); i++) mem_a[i] = DW'($urandom);
        pulse_error(1'b0, 1);
        while (bus_a.sgpr_raddr_o !== AW'(12) && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        n_cmp++;
        if (budget == 0) begin
            n_err++; $display("FAIL midrst_reach: raddr %0d want 12", bus_a.sgpr_raddr_o);
        end
        rst_n = 1'b0;
        #1;
        rec_a = 0; rec_b = 0;
        n_cmp++;
        if ({bus_a.fetch_block_o, bus_a.core_rf_we_o, bus_a.sgpr_raddr_o} !== '0 ||
            32'(bus_a.recovery_cnt_o) !== 32'd0) begin
            n_err++; $display("FAIL midrst_outputs: fetch %b we %b raddr %0d cnt %0d want 0",
                bus_a.fetch_block_o, bus_a.core_rf_we_o, bus_a.sgpr_raddr_o, bus_a.recovery_cnt_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_cmp++;
        if (wa_a.size() - wb != 11 || wa_a[wa_a.size()-1] !== AW'(11)) begin
            n_err++; $display("FAIL midrst_partial: got %0d writes last addr %0d want 11 last 11",
                wa_a.size() - wb, wa_a[wa_a.size()-1]);
        end
        wb = wa_a.size();
        db = done_a;
        pulse_error(1'b0, 1);
        rec_a++;
        wait_done(1'b0, db + 1);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (wa_a.size() - wb != NR - 1) begin
            n_err++; $display("FAIL midrst_full: got %0d writes want %0d", wa_a.size() - wb, NR - 1);
        end
        for (int k = 0; k < NR - 1 && wb + k < wa_a.size(); k++) begin
            n_cmp++;
            if (wa_a[wb+k] !== AW'(k + 1) || wd_a[wb+k] !== mem_a[k+1]) begin
                n_err++; $display("FAIL midrst_write[%0d]: got %0d/%h want %0d/%h", k,
                    wa_a[wb+k], wd_a[wb+k], k + 1, mem_a[k+1]);
            end
        end
        n_cmp++;
        if (32'(bus_a.recovery_cnt_o) !== 32'(exp_cnt(rec_a, CW))) begin
            n_err++; $display("FAIL midrst_cnt: got %0d want %0d", bus_a.recovery_cnt_o, exp_cnt(rec_a, CW));
        end
    endtask

    task automatic test_small_config();
        for (int r = 0; r < 5; r++) begin
            int wb = wa_b.size(), rb = run_b_q.size(), db = done_b;
            logic [DW-1:0] spc = DW'($urandom);
            for (int i = 0; i < (1 << AW); i++) mem_b[i] = DW'($urandom);
            bus_b.spc_i = spc;
            repeat ($urandom_range(4, 1)) @(posedge clk);
            pulse_error(1'b1, $urandom_range(6, 1));
            rec_b++;
            wait_done(1'b1, db + 1);
            repeat (3) @(negedge clk);
            #1;
            n_cmp++;
            if (wa_b.size() - wb != NR_B - 1) begin
                n_err++; $display("FAIL small_wcount[%0d]: got %0d want %0d", r, wa_b.size() - wb, NR_B - 1);
            end
            for (int k = 0; k < NR_B - 1 && wb + k < wa_b.size(); k++) begin
                n_cmp++;
                if (wa_b[wb+k] !== AW'(k + 1) || wd_b[wb+k] !== mem_b[k+1]) begin
                    n_err++; $display("FAIL small_write[%0d.%0d]: got %0d/%h want %0d/%h", r, k,
                        wa_b[wb+k], wd_b[wb+k], k + 1, mem_b[k+1]);
                end
            end
            n_cmp++;
            if (pc_b[pc_b.size()-1] !== spc || done_b - db != 1) begin
                n_err++; $display("FAIL small_pc_done[%0d]: got pc %h done %0d want pc %h done 1",
                    r, pc_b[pc_b.size()-1], done_b - db, spc);
            end
            n_cmp++;
            if (run_b_q.size() - rb != 1 || run_b_q[run_b_q.size()-1] != DC_B + NR_B + 1) begin
                n_err++; $display("FAIL small_fetch[%0d]: got %0d runs last %0d want 1 run %0d", r,
                    run_b_q.size() - rb, run_b_q[run_b_q.size()-1], DC_B + NR_B + 1);
            end
            n_cmp++;
            if (32'(bus_b.recovery_cnt_o) !== 32'(exp_cnt(rec_b, CW_B))) begin
                n_err++; $display("FAIL small_cnt[%0d]: got %0d want %0d", r,
                    bus_b.recovery_cnt_o, exp_cnt(rec_b, CW_B));
            end
        end
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (viol_a != 0 || viol_b != 0) begin
            n_err++; $display("FAIL invariants: got %0d/%0d violations want 0/0", viol_a, viol_b);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_reset_mid_restore();
        test_small_config();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
